regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 86 ++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, load) and the regfile write port.
// The arbiter uses the slave view; the requesters/regfile side uses the master view.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            a_valid;
    logic            a_ready;
    logic [4:0]      a_addr;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_addr;
    logic [XLEN-1:0] b_data;
    logic            wen;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic            init_done;

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, b_ready,
        output wen, waddr, wdata, init_done
    );

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, b_ready,
        input  wen, waddr, wdata, init_done
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register file: clears NREGS registers
// after reset, then grants one write per cycle with fair round-robin on contention.
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_wb_arbiter_if.slave  bus
);
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

    state_t          state_reg;
    logic [4:0]      count_reg;
    logic            prio_reg;      // 0 = requester A has priority, 1 = requester B
    logic            wen_reg;
    logic [4:0]      waddr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic            init_done_reg;

    logic            run;
    logic            a_grant;
    logic            b_grant;

    assign run     = (state_reg == ST_RUN);
    assign a_grant = run & bus.a_valid & (~bus.b_valid | ~prio_reg);
    assign b_grant = run & bus.b_valid & (~bus.a_valid |  prio_reg);

    assign bus.a_ready   = a_grant;
    assign bus.b_ready   = b_grant;
    assign bus.wen       = wen_reg;
    assign bus.waddr     = waddr_reg;
    assign bus.wdata     = wdata_reg;
    assign bus.init_done = init_done_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_CLEAR;
            count_reg     <= '0;
            prio_reg      <= 1'b0;
            wen_reg       <= 1'b0;
            waddr_reg     <= '0;
            wdata_reg     <= '0;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    wen_reg   <= 1'b1;
                    waddr_reg <= count_reg;
                    wdata_reg <= '0;
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == LAST_IDX) begin
                        state_reg     <= ST_RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                ST_RUN: begin
                    wen_reg <= 1'b0;
                    // Writes to r0 are accepted but dropped; address/data then hold.
                    if (a_grant) begin
                        wen_reg <= (bus.a_addr != 5'd0);
                        if (bus.a_addr != 5'd0) begin
                            waddr_reg <= bus.a_addr;
                            wdata_reg <= bus.a_data;
                        end
                    end else if (b_grant) begin
                        wen_reg <= (bus.b_addr != 5'd0);
                        if (bus.b_addr != 5'd0) begin
                            waddr_reg <= bus.b_addr;
                            wdata_reg <= bus.b_data;
                        end
                    end
                    if (bus.a_valid && bus.b_valid) begin
                        prio_reg <= ~prio_reg;
                    end
                end
                default: state_reg <= ST_CLEAR;
            endcase
        end
    end
endmodule
